io1_bscan_ctl: RTL and testbench
================================

# io1_bscan_ctl

Boundary-scan chain controller for the io1 pad ring. Drives the serial input, shift/update/mode controls and divided scan clock into the stitched pad boundary-scan chain (stage 0 nearest the serial input, last stage feeding the serial output). It also collects the bits returned at the chain tail. One `start` runs a full capture → shift → update sequence: a parallel word is loaded into the pad scan registers and the previously captured pad states are returned.

## Interface
- `CHAIN_LEN`, 43: number of scan stages in the chain; must be ≥ 2.
- `HALF`, 2: `clk` cycles per half period of `BScanClock`; must be ≥ 1.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan sequence; sampled only in IDLE.
- `mode_req`  in  1  value for `BScanMode`; latched with `start`.
- `wr_data`  in  CHAIN_LEN  word to load; bit k lands in stage k; latched with `start`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse at the end of the sequence.
- `rd_data`  out  CHAIN_LEN  captured chain contents; bit k comes from stage k; valid from the `done` cycle.
- `bscan_in`  out  1  serial data into the chain head.
- `bscan_out`  in  1  serial data from the chain tail.
- `BScanClock`  out  1  divided scan clock; pads act on its rising edge.
- `BScanShift`  out  1  1 = shift, 0 = capture/update.
- `BScanUpdate`  out  1  update strobe.
- `BScanMode`  out  1  pad boundary-scan mode select.

## Operation
- **Reset values:** `busy`=0, `done`=0, `rd_data`=0, `bscan_in`=0, `BScanClock`=0, `BScanShift`=0, `BScanUpdate`=0, `BScanMode`=0, state IDLE.
- **States:** IDLE → CAPTURE → SHIFT → UPDATE → DONE → IDLE.
- **Pulse unit:** every state except IDLE and DONE is built from scan-clock pulses. Each pulse is `BScanClock` low for HALF cycles, then high for HALF cycles. All control and data outputs change only at the start of a low phase.
- **IDLE:** on `start`=1, latch `wr_data` into the shift register and `mode_req` into `BScanMode`, then go to CAPTURE. Otherwise `start` is ignored.
- **CAPTURE:** one pulse with `BScanShift`=0 and `BScanUpdate`=0; the pads capture their pin states.
- **SHIFT:** `BScanShift`=1 for CHAIN_LEN pulses.
  - Pulse i (0-based) drives `bscan_in` = latched bit [CHAIN_LEN-1-i], so bits go out MSB first.
  - In the clk cycle where `BScanClock` rises, `bscan_out` is sampled into the receive register: `rx <= {rx[CHAIN_LEN-2:0], bscan_out}`.
  - A bit counter of width $clog2(CHAIN_LEN+1) terminates the state after exactly CHAIN_LEN rising edges.
- **UPDATE:** one pulse with `BScanShift`=0 and `BScanUpdate`=1; `BScanUpdate` returns to 0 as the pulse ends.
- **DONE:** one cycle.
  - `done`=1, `busy`=0, `rd_data` = rx.
  - `rd_data` then holds until the next `done` or `reset`.
  - `BScanMode` holds until the next `start`.
- **Reset mid-sequence:** all outputs take their reset values at the next edge. No update pulse is issued, and no `done` pulse.
- **Start in the DONE cycle:** ignored; it must be re-asserted in IDLE.

## Timing
- `start` sampled high at edge t → `busy`=1 from cycle t+1.
- `done` occurs at cycle t+1+2·HALF·(CHAIN_LEN+2). `busy` drops in that same cycle.
- Minimum `start`-to-`start` spacing is 2·HALF·(CHAIN_LEN+2)+2 cycles.
- `bscan_in` is stable for HALF cycles before each `BScanClock` rising edge and for HALF cycles after it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `IO1_BSCAN_CAPTURE_EN`.
- **Defined:** behaviour as above, including the CAPTURE state.
- **Undefined:** the CAPTURE state is removed. IDLE goes straight to SHIFT, `done` moves to t+1+2·HALF·(CHAIN_LEN+1), and `rd_data` returns the chain contents left by the previous sequence.

## Structure
- **`io1_bscan_pkg`** contains:
  - the state enum (IDLE, CAPTURE, SHIFT, UPDATE, DONE);
  - default values for CHAIN_LEN and HALF;
  - a bit-count width function.
- **`io1_bscan_tck_gen`** is the single sub-module. It holds the phase counter for HALF and outputs `BScanClock` plus one-cycle `fall_tick` and `rise_tick` strobes. The top-level FSM advances on these strobes.

## Test plan
- **Loopback, IO1_BSCAN_CAPTURE_EN defined:** 43-stage behavioural pad-chain model preloaded with capture values 43'h155_5555_5555; `start` with `wr_data`=43'h2AA_AAAA_AAAA.
  - Expected: `done` at t+181.
  - Expected: `rd_data`=43'h155_5555_5555.
  - Expected: the model's update registers equal 43'h2AA_AAAA_AAAA.
  - Expected: exactly 45 `BScanClock` rising edges.
- **Bit order:** `wr_data`=43'h1 (stage 0 only).
  - Expected: `bscan_in` high only during the last shift pulse.
  - Expected: the model's stage 0 ends at 1 and every other stage at 0.
- **Control sequencing:** `mode_req`=1.
  - Expected: `BScanMode`=1 from t+1 and held after `done`.
  - Expected: `BScanShift`=0 for the first and last pulse and 1 for the 43 middle pulses.
  - Expected: `BScanUpdate`=1 only during the final pulse.
- **Start while busy:** pulse `start` at t+50 and again in the `done` cycle.
  - Expected: no second sequence.
  - Expected: `busy` low at t+182.
- **Reset mid-shift:** assert `reset` at t+100.
  - Expected: all outputs 0 the next cycle.
  - Expected: no `BScanUpdate` and no `done`.
  - Expected: a following `start` completes normally.
- **IO1_BSCAN_CAPTURE_EN undefined:** run two sequences with `wr_data` A then B.
  - Expected: first `done` at t+177.
  - Expected: the second `rd_data` equals A.

Source files
------------

// File: rtl/io1_bscan_pkg.sv
// Shared types and defaults for the io1 pad-ring boundary-scan controller.
package io1_bscan_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 43;
  localparam int unsigned HALF_DEF      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE,
    ST_DONE
  } state_e;

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/io1_bscan_tck_gen.sv
// Scan-clock generator: HALF cycles low then HALF cycles high per pulse while run_i is set,
// with strobes flagging the cycle before the rising edge and before the end of a pulse.
module io1_bscan_tck_gen
  import io1_bscan_pkg::*;
#(
  parameter int unsigned HALF = HALF_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic tck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned     PW      = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
  localparam logic [PW-1:0]   PH_RISE = PW'(HALF - 1);
  localparam logic [PW-1:0]   PH_HIGH = PW'(HALF);
  localparam logic [PW-1:0]   PH_LAST = PW'(2 * HALF - 1);

  logic [PW-1:0] ph_q, ph_d;
  logic          active_q;

  // Phase 0 is the first low cycle of a pulse; the first cycle after run rises stays at 0.
  always_comb begin
    ph_d = '0;
    if (active_q && (ph_q != PH_LAST)) ph_d = ph_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q        <= '0;
      active_q    <= 1'b0;
      tck_o       <= 1'b0;
      rise_tick_o <= 1'b0;
      fall_tick_o <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      active_q    <= run_i;
      tck_o       <= run_i && (ph_d >= PH_HIGH);
      rise_tick_o <= run_i && (ph_d == PH_RISE);
      fall_tick_o <= run_i && (ph_d == PH_LAST);
    end
  end

endmodule

// File: rtl/io1_bscan_ctl.sv
// Boundary-scan chain controller: one start runs capture -> shift -> update over the pad ring.
// Define IO1_BSCAN_CAPTURE_EN to include the CAPTURE pulse ahead of shifting.
module io1_bscan_ctl
  import io1_bscan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned HALF      = HALF_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode_req,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 bscan_in,
  input  logic                 bscan_out,
  output logic                 BScanClock,
  output logic                 BScanShift,
  output logic                 BScanUpdate,
  output logic                 BScanMode
);

  localparam int unsigned   CW       = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN);

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [CHAIN_LEN-1:0] rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bin_q, bin_d;
  logic                 shift_q, shift_d;
  logic                 upd_q, upd_d;
  logic                 mode_q, mode_d;
  logic                 run_c;
  logic                 rise_tick, fall_tick;

  io1_bscan_tck_gen #(.HALF(HALF)) u_tck_gen (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run_c),
    .tck_o       (BScanClock),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // Controls change only on fall_tick, i.e. at the start of a low phase.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    shift_d = shift_q;
    upd_d   = upd_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d = wr_data;
          mode_d = mode_req;
          busy_d = 1'b1;
          cnt_d  = '0;
`ifdef IO1_BSCAN_CAPTURE_EN
          state_d = ST_CAPTURE;
          shift_d = 1'b0;
          bin_d   = 1'b0;
`else
          state_d = ST_SHIFT;
          shift_d = 1'b1;
          bin_d   = wr_data[CHAIN_LEN-1];
`endif
        end
      end
`ifdef IO1_BSCAN_CAPTURE_EN
      ST_CAPTURE: begin
        if (fall_tick) begin
          state_d = ST_SHIFT;
          shift_d = 1'b1;
          bin_d   = sreg_q[CHAIN_LEN-1];
        end
      end
`endif
      ST_SHIFT: begin
        if (rise_tick) begin
          rx_d  = {rx_q[CHAIN_LEN-2:0], bscan_out};
          cnt_d = cnt_q + CW'(1);
        end
        if (fall_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_UPDATE;
            shift_d = 1'b0;
            upd_d   = 1'b1;
            bin_d   = 1'b0;
          end else begin
            sreg_d = {sreg_q[CHAIN_LEN-2:0], 1'b0};
            bin_d  = sreg_q[CHAIN_LEN-2];
          end
        end
      end
      ST_UPDATE: begin
        if (fall_tick) begin
          state_d = ST_DONE;
          upd_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_d    = rx_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_c = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) || (state_d == ST_UPDATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= 1'b0;
      shift_q <= 1'b0;
      upd_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      shift_q <= shift_d;
      upd_q   <= upd_d;
      mode_q  <= mode_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_data     = rd_q;
  assign bscan_in    = bin_q;
  assign BScanShift  = shift_q;
  assign BScanUpdate = upd_q;
  assign BScanMode   = mode_q;

endmodule

// File: tb/tb_io1_bscan_ctl.sv
// Bench for io1_bscan_ctl: behavioural pad chain, cycle-level expectation model and directed checks.
module tb_io1_bscan_ctl;

  localparam int L = 43;
  localparam int H = 2;
`ifdef IO1_BSCAN_CAPTURE_EN
  localparam int NP = L + 2;
  localparam int FS = 1;
`else
  localparam int NP = L + 1;
  localparam int FS = 0;
`endif
  localparam int P2 = NP * 2 * H;

  logic         clk = 1'b0;
  logic         reset, start, mode_req;
  logic [L-1:0] wr_data;
  logic         busy, done, bscan_in, bscan_out;
  logic [L-1:0] rd_data;
  logic         BScanClock, BScanShift, BScanUpdate, BScanMode;

  io1_bscan_ctl #(.CHAIN_LEN(L), .HALF(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_req    (mode_req),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .rd_data     (rd_data),
    .bscan_in    (bscan_in),
    .bscan_out   (bscan_out),
    .BScanClock  (BScanClock),
    .BScanShift  (BScanShift),
    .BScanUpdate (BScanUpdate),
    .BScanMode   (BScanMode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {busy, done, bscan_in, BScanClock, BScanShift, BScanUpdate, BScanMode};
  endfunction

  // Pad ring: stage 0 at the head, tail drives bscan_out; pads act on BScanClock rising.
  logic [L-1:0] chain    = '0;
  logic [L-1:0] upd_reg  = '0;
  logic [L-1:0] cap_vals = '0;
  assign bscan_out = chain[L-1];
  always @(posedge BScanClock) begin
    if (BScanShift)       chain   <= {chain[L-2:0], bscan_in};
    else if (BScanUpdate) upd_reg <= chain;
    else                  chain   <= cap_vals;
  end

  // Per-pulse record of the controls seen at each scan-clock rise.
  int   rise_cnt = 0, bin_ones = 0, sh_ones = 0, up_ones = 0;
  int   done_cnt = 0, upd_cyc = 0;
  logic sh_at [4096];
  logic up_at [4096];
  logic bi_at [4096];
  always @(posedge BScanClock) begin
    if (rise_cnt < 4096) begin
      sh_at[rise_cnt] <= BScanShift;
      up_at[rise_cnt] <= BScanUpdate;
      bi_at[rise_cnt] <= bscan_in;
    end
    rise_cnt <= rise_cnt + 1;
    bin_ones <= bin_ones + (bscan_in ? 1 : 0);
    sh_ones  <= sh_ones + (BScanShift ? 1 : 0);
    up_ones  <= up_ones + (BScanUpdate ? 1 : 0);
  end
  always @(posedge clk) begin
    done_cnt <= done_cnt + (done ? 1 : 0);
    upd_cyc  <= upd_cyc + (BScanUpdate ? 1 : 0);
  end

  // Reference: k counts cycles since the accepting edge; the sequence is NP pulses of 2H cycles.
  bit           in_seq = 1'b0;
  int           k      = 0;
  logic [L-1:0] m_wr   = '0, m_rd = '0, m_rd_next = '0;
  logic         m_mode = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      in_seq <= 1'b0;
      k      <= 0;
      m_mode <= 1'b0;
      m_rd   <= '0;
    end else if (in_seq) begin
      k <= k + 1;
      if (k == P2)     m_rd   <= m_rd_next;
      if (k == P2 + 1) in_seq <= 1'b0;
    end else if (start) begin
      in_seq <= 1'b1;
      k      <= 1;
      m_wr   <= wr_data;
      m_mode <= mode_req;
`ifdef IO1_BSCAN_CAPTURE_EN
      m_rd_next <= cap_vals;
`else
      m_rd_next <= chain;
`endif
    end
  end

  always @(negedge clk) begin : cmp
    logic [6:0] e;
    int p, ph;
    if (chk_en) begin
      e = {6'b0, m_mode};
      if (in_seq && k <= P2) begin
        p  = (k - 1) / (2 * H);
        ph = (k - 1) % (2 * H);
        e[6] = 1'b1;
        e[3] = (ph >= H);
        if (p >= FS && p < FS + L) begin
          e[2] = 1'b1;
          e[4] = m_wr[L-1-(p-FS)];
        end
        if (p == NP - 1) e[1] = 1'b1;
      end else if (in_seq && k == P2 + 1) begin
        e[5] = 1'b1;
      end
      check("cycle_ctl", 64'(outs()), 64'(e));
      check("cycle_rd", 64'(rd_data), 64'(m_rd));
    end
  end

  int b_rise, b_bin, b_sh, b_up, b_done, b_upd;
  task automatic snap();
    b_rise = rise_cnt; b_bin = bin_ones; b_sh = sh_ones;
    b_up   = up_ones;  b_done = done_cnt; b_upd = upd_cyc;
  endtask

  task automatic do_start(input logic [L-1:0] w, input logic m);
    @(negedge clk);
    start = 1'b1; wr_data = w; mode_req = m;
    @(negedge clk);
    start = 1'b0; wr_data = L'({$urandom, $urandom}); mode_req = ~m;
    t0 = cyc;
  endtask

  // Latency in cycles from the accepting edge, counting the first busy cycle as t+1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin
        lat = cyc - t0 + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [L-1:0] a, b, w;
    int lat;
    reset = 1'b1; start = 1'b0; mode_req = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_ctl", 64'(outs()), 64'h0);
    check("reset_rd", 64'(rd_data), 64'h0);

    // Loopback with fixed capture / write patterns.
    cap_vals = 43'h155_5555_5555;
    snap();
    do_start(43'h2AA_AAAA_AAAA, 1'b0);
    check("busy_t1", 64'(busy), 64'h1);
    wait_done(lat);
`ifdef IO1_BSCAN_CAPTURE_EN
    check("loop_lat", 64'(lat), 64'd181);
    check("loop_rd", 64'(rd_data), 64'h155_5555_5555);
    check("loop_rises", 64'(rise_cnt - b_rise), 64'd45);
`else
    check("loop_lat", 64'(lat), 64'd177);
    check("loop_rises", 64'(rise_cnt - b_rise), 64'd44);
`endif
    check("loop_upd", 64'(upd_reg), 64'h2AA_AAAA_AAAA);

    // Bit order: only stage 0 set.
    snap();
    do_start(43'h1, 1'b0);
    wait_done(lat);
    check("bo_lat", 64'(lat), 64'(P2 + 1));
    check("bo_bin_ones", 64'(bin_ones - b_bin), 64'd1);
    check("bo_bin_last", 64'(bi_at[b_rise + NP - 2]), 64'h1);
    check("bo_chain", 64'(chain), 64'h1);
    check("bo_upd", 64'(upd_reg), 64'h1);

    // Control sequencing with mode set.
    snap();
    do_start(L'({$urandom, $urandom}), 1'b1);
    check("mode_t1", 64'(BScanMode), 64'h1);
    wait_done(lat);
    check("cs_sh_ones", 64'(sh_ones - b_sh), 64'(L));
    check("cs_sh_last", 64'(sh_at[b_rise + NP - 1]), 64'h0);
`ifdef IO1_BSCAN_CAPTURE_EN
    check("cs_sh_first", 64'(sh_at[b_rise]), 64'h0);
`endif
    check("cs_up_ones", 64'(up_ones - b_up), 64'd1);
    check("cs_up_last", 64'(up_at[b_rise + NP - 1]), 64'h1);
    check("cs_upd_cycles", 64'(upd_cyc - b_upd), 64'(2 * H));
    repeat (5) @(negedge clk);
    check("mode_hold", 64'(BScanMode), 64'h1);

    // Start while busy and in the done cycle.
    snap();
    do_start(L'({$urandom, $urandom}), 1'b0);
    while (cyc < t0 + 49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("sb_lat", 64'(lat), 64'(P2 + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sb_busy_after", 64'(busy), 64'h0);
    repeat (8) @(negedge clk);
    check("sb_no_second", 64'(rise_cnt - b_rise), 64'(NP));
    check("sb_done_cnt", 64'(done_cnt - b_done), 64'd1);

    // Reset in the middle of shifting.
    do_start(L'({$urandom, $urandom}), 1'b1);
    while (cyc < t0 + 99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ctl", 64'(outs()), 64'h0);
    check("rst_rd", 64'(rd_data), 64'h0);
    snap();
    repeat (200) @(negedge clk);
    check("rst_no_upd", 64'(upd_cyc - b_upd), 64'd0);
    check("rst_no_done", 64'(done_cnt - b_done), 64'd0);
    do_start(L'({$urandom, $urandom}), 1'b0);
    wait_done(lat);
    check("rst_restart_lat", 64'(lat), 64'(P2 + 1));

`ifndef IO1_BSCAN_CAPTURE_EN
    // Without capture, a sequence returns what the previous one left in the chain.
    a = L'({$urandom, $urandom});
    b = L'({$urandom, $urandom});
    do_start(a, 1'b0);
    wait_done(lat);
    check("nc_lat1", 64'(lat), 64'd177);
    do_start(b, 1'b0);
    wait_done(lat);
    check("nc_rd_prev", 64'(rd_data), 64'(a));
`endif

    // Randomized sequences with stray starts and occasional resets.
    for (int it = 0; it < 12; it++) begin
      cap_vals = L'({$urandom, $urandom});
      w = L'({$urandom, $urandom});
      do_start(w, 1'($urandom));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(170, 2)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        lat = -1;
        for (int i = 0; i < 400 && lat < 0; i++) begin
          start = ($urandom_range(5) == 0);
          if (done === 1'b1) lat = cyc - t0 + 1;
          else @(negedge clk);
        end
        check("rnd_lat", 64'(lat), 64'(P2 + 1));
        @(negedge clk);
        start = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
